spi_reg_bank: RTL and testbench
===============================

Name: spi_reg_bank

Overview:
SPI mode-0 slave and register file that sits directly upstream of the PWM generator. It turns 16-bit SPI frames from the off-chip host into writes and reads of a small bank of 8-bit configuration registers. Those registers (enable, prescaler, period, duty) drive the PWM core inputs. It runs in the system clock domain and oversamples SCLK; no SCLK-clocked logic.

Parameters:
NUM_REGS, 8, number of 8-bit registers; legal 1..128
RESET_VAL, 8'h00, reset value of every register

Ports:
clk  input  1  system clock; must be >= 4x SCLK frequency
rst_n  input  1  asynchronous active-low reset
spi_sclk  input  1  SPI clock from pin, asynchronous
spi_cs_n  input  1  SPI chip select, active low, asynchronous
spi_mosi  input  1  SPI data in, asynchronous
spi_miso  output  1  SPI data out
spi_miso_oe  output  1  pad output enable for MISO
reg_out  output  8*NUM_REGS  flattened registers; reg i at bits [8i+7:8i]
wr_strobe  output  1  one-cycle pulse when a register is written
wr_addr  output  7  address of the last committed write

Behaviour:
- Reset (async assert, sync release): all registers = RESET_VAL; spi_miso=0, spi_miso_oe=0, wr_strobe=0, wr_addr=0; bit counter=0; shift registers cleared.
- Sync: sclk, cs_n and mosi each pass through 2 flops. A third flop on sclk gives rise = s&~s_d and fall = ~s&s_d. Synchronized cs_n resets to 1.
- Frame, MSB first, 16 bits: bit15 R/W (1=write), bits14:8 addr[6:0], bits7:0 data (write data; ignored on reads).
- MOSI is sampled on a detected rise and MISO changes on a detected fall (mode 0). The bit counter (5 bits, saturating at 16) increments on each rise while cs_n_sync=0.
- cs_n_sync=1: counter cleared, shift registers cleared, spi_miso=0, spi_miso_oe=0. spi_miso_oe = ~cs_n_sync.
- Read: on the 8th rise, if R/W=0, load the shift-out register with reg[addr]. addr >= NUM_REGS loads 8'h00. MISO presents bit7 after the 8th fall, then bits 6..0 on the following falls. During bits 15..8 MISO=0.
- Write: on the 16th rise, if R/W=1 and addr < NUM_REGS, update reg[addr] with the data byte on the next clk edge. wr_strobe=1 for exactly that cycle; wr_addr=addr.
- addr >= NUM_REGS on a write: no register change, no strobe.
- Latency: a pin SCLK rise first sampled high at clk edge N gives rise at edge N+2. The register update and wr_strobe are visible after edge N+3.
- Abort: cs_n rising before the 16th rise discards the frame; no write, no strobe.
- Extra SCLK edges after 16 bits: ignored, no second write, MISO=0, until cs_n deasserts.
- Back-to-back frames need cs_n high for at least 3 clk cycles between them.
- Reset mid-frame: frame lost, registers return to RESET_VAL. The next frame after cs_n toggles is decoded normally.

Decomposition:
- Package pwm_pkg: SPI_FRAME_LEN=16, SPI_ADDR_W=7, register address constants (REG_CTRL=0, REG_PRESC=1, REG_PERIOD=2, REG_DUTY0=3...), typedef reg_byte_t (8 bits).
- Sub-module spi_sync: 2-flop synchronizer with optional rise/fall detect and parameterised reset value. Instanced for sclk (with edges), cs_n (reset 1) and mosi.

Test Plan:
- Write 0xA5 to addr 3 (frame 0x83A5, SCLK = clk/8) -> reg_out[31:24]=0xA5 three clk after the 16th rise; wr_strobe high 1 cycle; wr_addr=3; other registers unchanged.
- Read addr 3 (frame 0x0300) after the previous write -> MISO bits 8..15 = 1,0,1,0,0,1,0,1; MISO=0 during bits 0..7; spi_miso_oe high only while cs_n low.
- Abort: drive 0x85FF but raise cs_n after 10 bits -> reg5 stays 0x00; no wr_strobe.
- Out of range: write 0xC07F (addr 0x40) -> no change, no strobe. Reading addr 0x40 returns 0x00.
- Overrun: write frame 0x8111 followed by 8 extra SCLK pulses with mosi=1 -> reg1=0x11; exactly one strobe.
- Reset mid-frame: write 0x2C to reg2, then assert rst_n low at bit 12 of a new write frame -> all regs=0x00, outputs at reset values. A following full write frame succeeds.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the SPI register bank that feeds the PWM core.
// Frame geometry, register map and a small address range helper.
package pwm_pkg;

  localparam int SPI_FRAME_LEN = 16;
  localparam int SPI_ADDR_W    = 7;
  localparam int SPI_CNT_W     = 5;

  localparam int REG_CTRL   = 0;
  localparam int REG_PRESC  = 1;
  localparam int REG_PERIOD = 2;
  localparam int REG_DUTY0  = 3;

  typedef logic [7:0]            reg_byte_t;
  typedef logic [SPI_ADDR_W-1:0] spi_addr_t;
  typedef logic [SPI_CNT_W-1:0]  spi_cnt_t;

  function automatic logic addr_ok(
    input spi_addr_t a,
    input int        n
  );
    return int'(a) < n;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for an asynchronous pin, with an optional
// third flop providing single-cycle rise/fall pulses.
module spi_sync #(
  parameter logic RST_VAL = 1'b0,
  parameter bit   EDGES   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= {3{RST_VAL}};
    end else begin
      s_q <= {s_q[1:0], d_i};
    end
  end

  assign q_o    = s_q[1];
  assign rise_o = EDGES &  s_q[1] & ~s_q[2];
  assign fall_o = EDGES & ~s_q[1] &  s_q[2];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave decoding 16-bit frames into reads and writes of a
// small byte register bank; all logic runs on the oversampling clk.
module spi_reg_bank
  import pwm_pkg::*;
#(
  parameter int        NUM_REGS  = 8,
  parameter reg_byte_t RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [8*NUM_REGS-1:0] reg_out,
  output logic                  wr_strobe,
  output logic [SPI_ADDR_W-1:0] wr_addr
);

  localparam spi_cnt_t FULL = spi_cnt_t'(SPI_FRAME_LEN);
  localparam spi_cnt_t HALF = spi_cnt_t'(SPI_FRAME_LEN / 2);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync #(.RST_VAL(1'b0), .EDGES(1'b1)) u_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_sclk),
    .q_o    (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync #(.RST_VAL(1'b1), .EDGES(1'b0)) u_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_cs_n),
    .q_o    (cs_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync #(.RST_VAL(1'b0), .EDGES(1'b0)) u_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_mosi),
    .q_o    (mosi_s),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  assign unused_sync = ^{sclk_s, cs_rise, cs_fall,
                         mosi_rise, mosi_fall};

  reg_byte_t regs_q [NUM_REGS];

  spi_cnt_t  cnt_q,   cnt_d;
  logic [14:0] sin_q, sin_d;
  reg_byte_t sout_q,  sout_d;
  logic      miso_q,  miso_d;
  logic      pend_q,  pend_d;
  spi_addr_t paddr_q, paddr_d;
  reg_byte_t pdata_q, pdata_d;
  logic      stb_q,   stb_d;
  spi_addr_t waddr_q, waddr_d;

  logic [15:0] word;
  reg_byte_t   hdr;
  reg_byte_t   rdata;

  assign word = {sin_q, mosi_s};
  assign hdr  = {sin_q[6:0], mosi_s};

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hdr[6:0] == SPI_ADDR_W'(i)) rdata = regs_q[i];
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    sin_d   = sin_q;
    sout_d  = sout_q;
    miso_d  = miso_q;
    pend_d  = 1'b0;
    paddr_d = paddr_q;
    pdata_d = pdata_q;
    stb_d   = pend_q;
    waddr_d = pend_q ? paddr_q : waddr_q;
    if (cs_s) begin
      cnt_d  = '0;
      sin_d  = '0;
      sout_d = '0;
      miso_d = 1'b0;
    end else begin
      if (sclk_rise && cnt_q < FULL) begin
        cnt_d = cnt_q + 1'b1;
        sin_d = word[14:0];
        if (cnt_q == HALF - 1'b1) begin
          sout_d = hdr[7] ? '0 : rdata;
        end
        if (cnt_q == FULL - 1'b1 && word[15] &&
            addr_ok(word[14:8], NUM_REGS)) begin
          pend_d  = 1'b1;
          paddr_d = word[14:8];
          pdata_d = word[7:0];
        end
      end
      // Read data only occupies the second half; everything else shifts out 0.
      if (sclk_fall) begin
        if (cnt_q >= HALF && cnt_q < FULL) begin
          miso_d = sout_q[7];
          sout_d = {sout_q[6:0], 1'b0};
        end else begin
          miso_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sin_q   <= '0;
      sout_q  <= '0;
      miso_q  <= 1'b0;
      pend_q  <= 1'b0;
      paddr_q <= '0;
      pdata_q <= '0;
      stb_q   <= 1'b0;
      waddr_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sin_q   <= sin_d;
      sout_q  <= sout_d;
      miso_q  <= miso_d;
      pend_q  <= pend_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
      stb_q   <= stb_d;
      waddr_q <= waddr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (pend_q) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (paddr_q == SPI_ADDR_W'(i)) regs_q[i] <= pdata_q;
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[8*i +: 8] = regs_q[i];
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = ~cs_s;
  assign wr_strobe   = stb_q;
  assign wr_addr     = waddr_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed frames plus random traffic, checked
// every cycle against a frame-level register model.
module tb_spi_reg_bank;
  import pwm_pkg::*;

  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe, wr_strobe;
  logic [8*NR-1:0] reg_out;
  logic [6:0] wr_addr;

  spi_reg_bank #(.NUM_REGS(NR), .RESET_VAL(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sclk    (sclk),
    .spi_cs_n    (cs_n),
    .spi_mosi    (mosi),
    .spi_miso    (miso),
    .spi_miso_oe (miso_oe),
    .reg_out     (reg_out),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  typedef struct {
    int         c;
    logic [6:0] a;
    logic [7:0] d;
  } commit_t;

  logic [7:0] m_regs [NR];
  logic [6:0] m_waddr = '0;
  commit_t    pend_q [$];

  function automatic void chk(
    input string       n,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  function automatic logic [8*NR-1:0] flat();
    logic [8*NR-1:0] v;
    for (int i = 0; i < NR; i++) v[8*i +: 8] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_waddr = '0;
    pend_q.delete();
  endtask

  always @(negedge clk) begin
    bit      es;
    commit_t t;
    es = 1'b0;
    if (!rst_n) begin
      chk("rst_reg_out", reg_out, 64'h0);
      chk("rst_strobe", wr_strobe, 0);
      chk("rst_waddr", wr_addr, 0);
      chk("rst_miso", miso, 0);
      chk("rst_oe", miso_oe, 0);
    end else begin
      while (pend_q.size() > 0 && pend_q[0].c <= cyc) begin
        t = pend_q.pop_front();
        m_regs[t.a] = t.d;
        m_waddr = t.a;
        es = 1'b1;
      end
      chk("reg_out", reg_out, flat());
      chk("wr_strobe", wr_strobe, es);
      chk("wr_addr", wr_addr, m_waddr);
      if (wr_strobe) strobes++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs one frame; host samples MISO just before each SCLK rise.
  task automatic spi_frame(
    input  logic [15:0] f,
    input  int          nbits,
    input  int          extra,
    input  int          rst_bit,
    input  int          hp,
    output logic [7:0]  rx
  );
    logic [6:0] a;
    logic [7:0] exp_rd;
    logic       e;
    rx = '0;
    a = f[14:8];
    exp_rd = (!f[15] && int'(a) < NR) ? m_regs[a] : 8'h00;
    cs_n = 1'b0;
    tick(hp);
    for (int i = 0; i < nbits + extra; i++) begin
      if (i == rst_bit) begin
        rst_n = 1'b0;
        model_reset();
        tick(3);
        chk("rst_mid_regs", reg_out, 64'h0);
        rst_n = 1'b1;
        cs_n = 1'b1;
        mosi = 1'b0;
        tick(6);
        return;
      end
      mosi = (i < 16) ? f[15-i] : 1'b1;
      tick(hp);
      e = (i >= 8 && i < 16) ? exp_rd[15-i] : 1'b0;
      chk("miso", miso, e);
      chk("miso_oe", miso_oe, 1);
      if (i >= 8 && i < 16) rx[15-i] = miso;
      sclk = 1'b1;
      if (i == 15 && f[15] && int'(a) < NR)
        pend_q.push_back('{cyc + 4, a, f[7:0]});
      tick(hp);
      sclk = 1'b0;
    end
    tick(hp);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(4);
    chk("idle_oe", miso_oe, 0);
    chk("idle_miso", miso, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  rx;
    logic [15:0] f;
    int s0, nb, ex;
    model_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("reset_regs", reg_out, 64'h0);
    chk("reset_ctrl", reg_out[8*REG_CTRL +: 8], 8'h00);
    chk("reset_waddr", wr_addr, 0);

    s0 = strobes;
    spi_frame(16'h83A5, 16, 0, -1, 4, rx);
    chk("wr_duty0", reg_out[8*REG_DUTY0 +: 8], 8'hA5);
    chk("wr_addr3", wr_addr, 7'd3);
    chk("wr_stb1", strobes - s0, 1);
    chk("wr_others", reg_out, 64'h00000000_A5000000);

    spi_frame(16'h0300, 16, 0, -1, 4, rx);
    chk("rd_duty0", rx, 8'hA5);

    s0 = strobes;
    spi_frame(16'h85FF, 10, 0, -1, 4, rx);
    chk("abort_reg5", reg_out[47:40], 8'h00);
    chk("abort_stb", strobes - s0, 0);

    s0 = strobes;
    spi_frame(16'hC07F, 16, 0, -1, 4, rx);
    chk("oor_stb", strobes - s0, 0);
    chk("oor_regs", reg_out, 64'h00000000_A5000000);
    spi_frame(16'h4000, 16, 0, -1, 4, rx);
    chk("oor_rd", rx, 8'h00);

    s0 = strobes;
    spi_frame(16'h8111, 16, 8, -1, 4, rx);
    chk("ovr_presc", reg_out[8*REG_PRESC +: 8], 8'h11);
    chk("ovr_stb", strobes - s0, 1);

    spi_frame(16'h822C, 16, 0, -1, 4, rx);
    chk("wr_period", reg_out[8*REG_PERIOD +: 8], 8'h2C);
    spi_frame(16'h8355, 16, 0, 12, 4, rx);
    chk("rst_all", reg_out, 64'h0);
    chk("rst_waddr2", wr_addr, 0);
    spi_frame(16'h8377, 16, 0, -1, 4, rx);
    chk("post_rst_wr", reg_out[8*REG_DUTY0 +: 8], 8'h77);

    for (int k = 0; k < 40; k++) begin
      f[15] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) f[14:8] = 7'($urandom_range(0, 127));
      else f[14:8] = 7'($urandom_range(0, NR - 1));
      f[7:0] = 8'($urandom);
      nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 15)) : 16;
      ex = (nb == 16 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      spi_frame(f, nb, ex, -1, int'($urandom_range(4, 6)), rx);
    end

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
